// File: rtl/multi_mode_sequencer.sv
// SLM image / galvo position sequencer locked to the VGA frame sync.
// Generates ms-length camera and galvo trigger pulses, with ack timeout, abort and done.
module multi_mode_sequencer #(
  parameter int unsigned IMG_W        = 7,
  parameter int unsigned CYC_W        = 16,
  parameter int unsigned POS_W        = 32,
  parameter int unsigned FID_W        = 6,
  parameter int unsigned DEJITTER     = 8,
  parameter int unsigned TICKS_PER_MS = 50000,
  parameter int unsigned MS_W         = 8,
  parameter int unsigned TO_W         = 16
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [MS_W-1:0]  iCAMERA_TRIGGER_MILLISEC,
  input  logic [MS_W-1:0]  iGALVO_TRIGGER_MILLISEC,
  input  logic [TO_W-1:0]  iGALVO_TIMEOUT_MILLISEC,
  input  logic [IMG_W-1:0] iNUM_SLM_IMAGES,
  input  logic [CYC_W-1:0] iCYCLES_OF_DISPLAY_FOR_EACH_IMAGE,
  input  logic [POS_W-1:0] iNUM_OF_GALVO_POSITIONS,
  input  logic             iTRIG_WITHOUT_GALVO,
  input  logic             iTRIG_WITH_GALVO,
  input  logic             iABORT,
  input  logic             iGALVO_ACK,
  input  logic             iVGA_FRAME_SYNC,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oTIMEOUT_ERR,
  output logic             oCAMERA_TRIGGER,
  output logic             oGALVO_CHANGE_TRIGGER,
  output logic [FID_W-1:0] oCURRENT_DISPLAY_FRAME_ID,
  output logic [POS_W-1:0] oCURRENT_GALVO_POSITION
);

  localparam int unsigned PW = MS_W + $clog2(TICKS_PER_MS + 1);
  localparam int unsigned TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [TW-1:0] TickMax = TW'(TICKS_PER_MS - 1);

  typedef enum logic [3:0] {
    StIdle, StLatch, StSigGalvo, StWaitGalvo, StWaitVga1,
    StWaitVga2, StSigCam, StCount, StNextImg, StNextPos
  } state_e;

  state_e            state_q, state_d;
  logic [DEJITTER-1:0] sync_sr_q;
  logic [DEJITTER:0] sync_shift;
  logic              sync_f, sync_f_q, neg_edge_q;
  logic              galvo_mode_q, galvo_mode_d;
  logic [IMG_W-1:0]  n_img_q, n_img_d, img_q, img_d;
  logic [CYC_W-1:0]  n_cyc_q, n_cyc_d, cyc_q, cyc_d;
  logic [POS_W-1:0]  n_pos_q, n_pos_d, pos_q, pos_d;
  logic              ack_seen_q, ack_seen_d;
  logic [1:0]        edge_cnt_q, edge_cnt_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [TO_W-1:0]   ms_q, ms_d, to_q, to_d;
  logic              err_q, err_d, done_q, done_d;
  logic [PW-1:0]     cam_cnt_q, cam_cnt_d, gal_cnt_q, gal_cnt_d;
  logic [IMG_W:0]    img_inc;
  logic [POS_W:0]    pos_inc;
  logic [TO_W:0]     ms_next;
  logic              abort_act;

  // Frame sync filter: OR over the last DEJITTER samples swallows short low glitches.
  assign sync_shift = {sync_sr_q, iVGA_FRAME_SYNC};
  assign sync_f     = |sync_sr_q;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync_sr_q  <= '0;
      sync_f_q   <= 1'b0;
      neg_edge_q <= 1'b0;
    end else begin
      sync_sr_q  <= sync_shift[DEJITTER-1:0];
      sync_f_q   <= sync_f;
      neg_edge_q <= sync_f_q & ~sync_f;
    end
  end

  assign abort_act = iABORT && (state_q != StIdle);
  assign img_inc   = {1'b0, img_q} + {{IMG_W{1'b0}}, 1'b1};
  assign pos_inc   = {1'b0, pos_q} + {{POS_W{1'b0}}, 1'b1};
  assign ms_next   = {1'b0, ms_q} + {{TO_W{1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    galvo_mode_d = galvo_mode_q;
    n_img_d      = n_img_q;
    n_cyc_d      = n_cyc_q;
    n_pos_d      = n_pos_q;
    img_d        = img_q;
    cyc_d        = cyc_q;
    pos_d        = pos_q;
    ack_seen_d   = ack_seen_q;
    edge_cnt_d   = edge_cnt_q;
    tick_d       = tick_q;
    ms_d         = ms_q;
    to_d         = to_q;
    err_d        = err_q;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (iTRIG_WITH_GALVO || iTRIG_WITHOUT_GALVO) begin
          galvo_mode_d = iTRIG_WITH_GALVO;
          err_d        = 1'b0;
          state_d      = StLatch;
        end
      end
      StLatch: begin
        n_img_d = iNUM_SLM_IMAGES;
        n_cyc_d = iCYCLES_OF_DISPLAY_FOR_EACH_IMAGE;
        n_pos_d = iNUM_OF_GALVO_POSITIONS;
        img_d   = '0;
        cyc_d   = '0;
        pos_d   = '0;
        if (iNUM_SLM_IMAGES == '0 || iCYCLES_OF_DISPLAY_FOR_EACH_IMAGE == '0 ||
            (galvo_mode_q && iNUM_OF_GALVO_POSITIONS == '0)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = galvo_mode_q ? StSigGalvo : StWaitVga1;
        end
      end
      StSigGalvo: begin
        ack_seen_d = 1'b0;
        edge_cnt_d = 2'd0;
        tick_d     = '0;
        ms_d       = '0;
        to_d       = iGALVO_TIMEOUT_MILLISEC;
        state_d    = StWaitGalvo;
      end
      StWaitGalvo: begin
        if (iGALVO_ACK) ack_seen_d = 1'b1;
        if (neg_edge_q && edge_cnt_q != 2'd3) edge_cnt_d = edge_cnt_q + 2'd1;
        if (tick_q == TickMax) begin
          tick_d = '0;
          ms_d   = ms_next[TO_W-1:0];
        end else begin
          tick_d = tick_q + {{(TW-1){1'b0}}, 1'b1};
        end
        if (ack_seen_q && edge_cnt_q >= 2'd2) begin
          state_d = StSigCam;
        end else if (to_q != '0 && tick_q == TickMax && ms_next == {1'b0, to_q}) begin
          err_d   = 1'b1;
          img_d   = '0;
          pos_d   = '0;
          state_d = StIdle;
        end
      end
      StWaitVga1: if (neg_edge_q) state_d = StWaitVga2;
      StWaitVga2: if (neg_edge_q) state_d = StSigCam;
      StSigCam: begin
        cyc_d   = '0;
        state_d = StCount;
      end
      StCount: begin
        if (cyc_q == n_cyc_q) state_d = StNextImg;
        else if (neg_edge_q) cyc_d = cyc_q + {{(CYC_W-1){1'b0}}, 1'b1};
      end
      StNextImg: begin
        if (img_inc < {1'b0, n_img_q}) begin
          img_d   = img_inc[IMG_W-1:0];
          state_d = StWaitVga1;
        end else begin
          img_d = '0;
          if (galvo_mode_q) begin
            state_d = StNextPos;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StNextPos: begin
        if (pos_inc < {1'b0, n_pos_q}) begin
          pos_d   = pos_inc[POS_W-1:0];
          state_d = StSigGalvo;
        end else begin
          pos_d   = '0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort_act) begin
      state_d    = StIdle;
      img_d      = '0;
      cyc_d      = '0;
      pos_d      = '0;
      ack_seen_d = 1'b0;
      edge_cnt_d = 2'd0;
      done_d     = 1'b0;
      err_d      = err_q;
    end
  end

  // Pulse generators: load N*TICKS_PER_MS on fire, count down; a re-fire restarts the count.
  always_comb begin
    cam_cnt_d = cam_cnt_q;
    gal_cnt_d = gal_cnt_q;
    if (abort_act) begin
      cam_cnt_d = '0;
      gal_cnt_d = '0;
    end else begin
      if (state_q == StSigCam) begin
        cam_cnt_d = PW'(iCAMERA_TRIGGER_MILLISEC) * PW'(TICKS_PER_MS);
      end else if (cam_cnt_q != '0) begin
        cam_cnt_d = cam_cnt_q - {{(PW-1){1'b0}}, 1'b1};
      end
      if (state_q == StSigGalvo) begin
        gal_cnt_d = PW'(iGALVO_TRIGGER_MILLISEC) * PW'(TICKS_PER_MS);
      end else if (gal_cnt_q != '0) begin
        gal_cnt_d = gal_cnt_q - {{(PW-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= StIdle;
      galvo_mode_q <= 1'b0;
      n_img_q      <= '0;
      n_cyc_q      <= '0;
      n_pos_q      <= '0;
      img_q        <= '0;
      cyc_q        <= '0;
      pos_q        <= '0;
      ack_seen_q   <= 1'b0;
      edge_cnt_q   <= 2'd0;
      tick_q       <= '0;
      ms_q         <= '0;
      to_q         <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      cam_cnt_q    <= '0;
      gal_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      galvo_mode_q <= galvo_mode_d;
      n_img_q      <= n_img_d;
      n_cyc_q      <= n_cyc_d;
      n_pos_q      <= n_pos_d;
      img_q        <= img_d;
      cyc_q        <= cyc_d;
      pos_q        <= pos_d;
      ack_seen_q   <= ack_seen_d;
      edge_cnt_q   <= edge_cnt_d;
      tick_q       <= tick_d;
      ms_q         <= ms_d;
      to_q         <= to_d;
      err_q        <= err_d;
      done_q       <= done_d;
      cam_cnt_q    <= cam_cnt_d;
      gal_cnt_q    <= gal_cnt_d;
    end
  end

  assign oBUSY                     = (state_q != StIdle);
  assign oDONE                     = done_q;
  assign oTIMEOUT_ERR              = err_q;
  assign oCAMERA_TRIGGER           = (cam_cnt_q != '0);
  assign oGALVO_CHANGE_TRIGGER     = (gal_cnt_q != '0);
  assign oCURRENT_DISPLAY_FRAME_ID = img_q[FID_W-1:0];
  assign oCURRENT_GALVO_POSITION   = pos_q;

endmodule

// File: tb/tb_multi_mode_sequencer.sv
// Scoreboard bench for multi_mode_sequencer: stimulus pushes expected pulse/done/error events,
// a monitor reconstructs events from the outputs and compares them in order.
module tb_multi_mode_sequencer;

  localparam int unsigned TPM      = 10;
  localparam int          SyncPer  = 200;
  localparam int          SyncHigh = 40;
  localparam int          KCam     = 0;
  localparam int          KGal     = 1;
  localparam int          KDone    = 2;
  localparam int          KErr     = 3;

  logic        clk, rst_n;
  logic [7:0]  cam_ms, gal_ms;
  logic [15:0] to_ms;
  logic [6:0]  n_img;
  logic [15:0] n_cyc;
  logic [31:0] n_pos;
  logic        trig_without, trig_with, abort, ack, vga_sync;
  logic        busy, done, err, cam, gal;
  logic [5:0]  fid;
  logic [31:0] pos;

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  sync_cnt = 0;
  int  sync_falls = 0;
  int  trig_falls = 0;
  bit  glitch_en = 0;
  bit  ack_en = 1;

  multi_mode_sequencer #(.TICKS_PER_MS(TPM)) dut (
    .iCLK                             (clk),
    .iRST_N                           (rst_n),
    .iCAMERA_TRIGGER_MILLISEC         (cam_ms),
    .iGALVO_TRIGGER_MILLISEC          (gal_ms),
    .iGALVO_TIMEOUT_MILLISEC          (to_ms),
    .iNUM_SLM_IMAGES                  (n_img),
    .iCYCLES_OF_DISPLAY_FOR_EACH_IMAGE(n_cyc),
    .iNUM_OF_GALVO_POSITIONS          (n_pos),
    .iTRIG_WITHOUT_GALVO              (trig_without),
    .iTRIG_WITH_GALVO                 (trig_with),
    .iABORT                           (abort),
    .iGALVO_ACK                       (ack),
    .iVGA_FRAME_SYNC                  (vga_sync),
    .oBUSY                            (busy),
    .oDONE                            (done),
    .oTIMEOUT_ERR                     (err),
    .oCAMERA_TRIGGER                  (cam),
    .oGALVO_CHANGE_TRIGGER            (gal),
    .oCURRENT_DISPLAY_FRAME_ID        (fid),
    .oCURRENT_GALVO_POSITION          (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push(input int kind, input int a, input int b, input int c);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic emit(input int kind, input int a, input int b, input int c);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got kind=%0d a=%0d b=%0d c=%0d expected no event",
               kind, a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a != a || e.b != b || e.c != c) begin
        n_fail++;
        $display("FAIL sb_event: got kind=%0d a=%0d b=%0d c=%0d expected kind=%0d a=%0d b=%0d c=%0d",
                 kind, a, b, c, e.kind, e.a, e.b, e.c);
      end
    end
  endtask

  // VGA sync: high for SyncHigh clocks each SyncPer, optional 3-clock low glitch inside the high.
  initial begin
    vga_sync = 1'b1;
    forever begin
      @(negedge clk);
      sync_cnt = (sync_cnt + 1) % SyncPer;
      vga_sync = (sync_cnt < SyncHigh) && !(glitch_en && sync_cnt >= 15 && sync_cnt <= 17);
      if (sync_cnt == SyncHigh) sync_falls++;
    end
  end

  // Galvo ack 50 clocks after each galvo pulse starts.
  initial begin
    ack = 1'b0;
    forever begin
      @(posedge gal);
      if (ack_en) begin
        repeat (50) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    end
  end

  // Monitor: rebuilds events from outputs and checks them against the scoreboard.
  initial begin
    logic cam_p, gal_p, err_p;
    int   cam_len, cam_fid, cam_pos, gal_len, gal_pos, gal_age;
    cam_p = 0; gal_p = 0; err_p = 0;
    cam_len = 0; cam_fid = 0; cam_pos = 0; gal_len = 0; gal_pos = 0; gal_age = 0;
    forever begin
      @(negedge clk);
      if (cam && !cam_p) begin
        cam_fid = int'(fid); cam_pos = int'(pos); cam_len = 0;
      end
      if (cam) cam_len++;
      if (!cam && cam_p) emit(KCam, cam_fid, cam_pos, cam_len);
      if (gal && !gal_p) begin
        gal_pos = int'(pos); gal_len = 0; gal_age = 0;
      end else begin
        gal_age++;
      end
      if (gal) gal_len++;
      if (!gal && gal_p) emit(KGal, gal_pos, 0, gal_len);
      if (done) emit(KDone, sync_falls - trig_falls, 0, 0);
      if (err && !err_p) emit(KErr, gal_age, 0, 0);
      cam_p = cam; gal_p = gal; err_p = err;
    end
  end

  task automatic start_run(input logic w_g, input logic wo_g, input int imgs, input int cycs,
                           input int poss, input int cms, input int gms, input int tms);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (sync_cnt != 100 && guard < 2 * SyncPer);
    n_img = 7'(imgs); n_cyc = 16'(cycs); n_pos = 32'(poss);
    cam_ms = 8'(cms); gal_ms = 8'(gms); to_ms = 16'(tms);
    trig_with = w_g; trig_without = wo_g;
    trig_falls = sync_falls;
    @(negedge clk);
    trig_with = 1'b0; trig_without = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_cam(input int budget, input string name);
    int n;
    n = 0;
    while (!cam && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, cam, 1);
  endtask

  initial begin
    #(400000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; abort = 1'b0; trig_with = 1'b0; trig_without = 1'b0;
    n_img = '0; n_cyc = '0; n_pos = '0; cam_ms = '0; gal_ms = '0; to_ms = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cam", cam, 0);
    check("rst_gal", gal, 0);
    check("rst_fid", fid, 0);
    check("rst_pos", pos, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // 1: no-galvo, 3 images x 2 frames, 1 ms camera pulses
    push(KCam, 0, 0, 10); push(KCam, 1, 0, 10); push(KCam, 2, 0, 10); push(KDone, 12, 0, 0);
    start_run(1'b0, 1'b1, 3, 2, 0, 1, 1, 0);
    check("t1_busy", busy, 1);
    wait_idle(4000, "t1_idle");

    // 2: galvo, 2 positions x 2 images x 1 frame
    push(KGal, 0, 0, 10); push(KCam, 0, 0, 10); push(KCam, 1, 0, 10);
    push(KGal, 1, 0, 10); push(KCam, 0, 1, 10); push(KCam, 1, 1, 10); push(KDone, 12, 0, 0);
    start_run(1'b1, 1'b0, 2, 1, 2, 1, 1, 0);
    wait_idle(4000, "t2_idle");

    // 3: ack never arrives, 3 ms timeout
    ack_en = 0;
    push(KGal, 0, 0, 10); push(KErr, 30, 0, 0);
    start_run(1'b1, 1'b0, 1, 1, 1, 1, 1, 3);
    wait_idle(500, "t3_idle");
    check("t3_err_sticky", err, 1);
    ack_en = 1;

    // 4: both triggers at once, then triggers while busy are ignored
    push(KGal, 0, 0, 10); push(KCam, 0, 0, 10); push(KDone, 3, 0, 0);
    start_run(1'b1, 1'b1, 1, 1, 1, 1, 1, 0);
    check("t4_err_cleared", err, 0);
    for (int i = 0; i < 2; i++) begin
      repeat (200) @(negedge clk);
      check("t4_busy_before_retrig", busy, 1);
      trig_with = 1'b1; trig_without = 1'b1;
      @(negedge clk);
      trig_with = 1'b0; trig_without = 1'b0;
    end
    wait_idle(2000, "t4_idle");

    // 5: zero images -> done straight from latch
    push(KDone, 0, 0, 0);
    start_run(1'b0, 1'b1, 0, 2, 0, 1, 1, 0);
    check("t5_latch_busy", busy, 1);
    check("t5_latch_done", done, 0);
    @(negedge clk);
    check("t5_done", done, 1);
    check("t5_idle", busy, 0);
    repeat (5) @(negedge clk);

    // 6: abort while camera pulse active
    push(KCam, 0, 0, 6);
    start_run(1'b0, 1'b1, 2, 2, 0, 5, 1, 0);
    wait_cam(2000, "t6_cam_rise");
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t6_abort_cam", cam, 0);
    check("t6_abort_busy", busy, 0);
    repeat (400) @(negedge clk);

    // 7: glitched sync must not count as a frame
    glitch_en = 1;
    push(KCam, 0, 0, 10); push(KDone, 3, 0, 0);
    start_run(1'b0, 1'b1, 1, 1, 0, 1, 1, 0);
    wait_idle(2000, "t7_idle");
    glitch_en = 0;

    // 8: async reset mid-pulse
    push(KCam, 0, 0, 3);
    start_run(1'b0, 1'b1, 2, 1, 0, 5, 1, 0);
    wait_cam(2000, "t8_cam_rise");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t8_rst_cam", cam, 0);
    check("t8_rst_busy", busy, 0);
    check("t8_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("t8_still_idle", busy, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
